// File: rtl/pcs_pkg.sv
// Shared types, control characters and block classifier for the transmit PCS sequencer.
package pcs_pkg;

  typedef enum logic [2:0] {INIT, C, D, T, E} tx_state_t;
  typedef enum logic [2:0] {BT_C, BT_S, BT_D, BT_T, BT_E} blk_type_t;

  localparam logic [7:0]  CTL_IDLE   = 8'h07;
  localparam logic [7:0]  CTL_START  = 8'hFB;
  localparam logic [7:0]  CTL_TERM   = 8'hFD;
  localparam logic [7:0]  CTL_ERROR  = 8'hFE;
  localparam logic [7:0]  CTL_SEQ    = 8'h9C;
  localparam logic [0:63] LBLOCK     = 64'h9C000001_9C000001;
  localparam logic [0:7]  LBLOCK_CTL = 8'h88;
  localparam logic [0:63] EBLOCK     = {8{CTL_ERROR}};
  localparam logic [0:7]  EBLOCK_CTL = 8'hFF;

  // A 4-lane half is control-only: all idle/error characters, or an ordered set in its lane 0.
  function automatic logic half_is_ctl(input logic [0:31] d, input logic [0:3] c);
    logic ok;
    ok = (c == 4'b1000) && (d[0:7] == CTL_SEQ);
    if (c == 4'b1111) begin
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (d[8*i +: 8] != CTL_IDLE && d[8*i +: 8] != CTL_ERROR) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic blk_type_t classify_block(input logic [0:63] d, input logic [0:7] c);
    blk_type_t  bt;
    logic [2:0] first;
    logic       found;
    logic       tail_ok;
    bt    = BT_E;
    first = 3'd0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (c[i] && !found) begin
        found = 1'b1;
        first = 3'(i);
      end
    end
    tail_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i > int'(first) && (!c[i] || d[8*i +: 8] != CTL_IDLE)) tail_ok = 1'b0;
    end
    if (half_is_ctl(d[0:31], c[0:3]) && half_is_ctl(d[32:63], c[4:7])) begin
      bt = BT_C;
    end else if (c == 8'h80 && d[0:7] == CTL_START) begin
      bt = BT_S;
    end else if (c == 8'hF8 && d[32:39] == CTL_START && d[0:31] == {4{CTL_IDLE}}) begin
      bt = BT_S;
    end else if (c == 8'h00) begin
      bt = BT_D;
    end else if (found && d[8*first +: 8] == CTL_TERM && tail_ok) begin
      bt = BT_T;
    end
    return bt;
  endfunction

endpackage

// File: rtl/gearbox_seq_counter.sv
// Word phase and gearbox sequence counter; requests a MAC pause for one block period per sequence.
module gearbox_seq_counter #(
  parameter int unsigned SEQ_MAX   = 32,
  parameter int unsigned PAUSE_SEQ = 32
) (
  input  logic       i_txc,
  input  logic       i_reset_n,
  output logic       o_txc2,
  output logic [5:0] o_gearbox_seq,
  output logic       o_tx_pause
);
  localparam logic [5:0] SEQ_LAST  = 6'(SEQ_MAX);
  localparam logic [5:0] SEQ_PAUSE = 6'(PAUSE_SEQ);

  logic       r_txc2;
  logic [5:0] r_seq;

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_txc2 <= 1'b0;
      r_seq  <= 6'd0;
    end else begin
      r_txc2 <= ~r_txc2;
      if (r_txc2) r_seq <= (r_seq == SEQ_LAST) ? 6'd0 : r_seq + 6'd1;
    end
  end

  // The sequence only moves after the second word, so the pause spans a whole word pair.
  assign o_txc2        = r_txc2;
  assign o_gearbox_seq = r_seq;
  assign o_tx_pause    = (r_seq == SEQ_PAUSE);

endmodule

// File: rtl/tx_pcs_sequencer.sv
// Transmit PCS sequencer: pairs MAC words into 64-bit blocks around the gearbox pause and runs
// the transmit state machine that replaces illegal control sequences with error blocks.
module tx_pcs_sequencer
  import pcs_pkg::*;
#(
  parameter int unsigned SEQ_MAX   = 32,
  parameter int unsigned PAUSE_SEQ = 32
) (
  input  logic        i_txc,
  input  logic        i_reset_n,
  input  logic        i_init_done,
  input  logic [0:31] i_txd,
  input  logic [0:3]  i_txctl,
  output logic        o_tx_pause,
  output logic [0:63] o_txd,
  output logic [0:7]  o_txctl,
  output logic        o_block_valid,
  output logic        o_txc2,
  output logic [5:0]  o_gearbox_seq,
  output logic [2:0]  o_tx_state
);
  logic        w_txc2;
  logic        w_pause;
  logic        w_form_block;
  logic [5:0]  w_seq;
  logic [0:31] r_word0;
  logic [0:3]  r_ctl0;
  logic [0:63] w_blk;
  logic [0:7]  w_blk_ctl;
  logic [0:63] w_out_txd;
  logic [0:7]  w_out_ctl;
  logic [0:63] r_txd;
  logic [0:7]  r_txctl;
  logic        r_block_valid;
  blk_type_t   w_blk_type;
  tx_state_t   r_state;
  tx_state_t   w_next_state;

  gearbox_seq_counter #(
    .SEQ_MAX  (SEQ_MAX),
    .PAUSE_SEQ(PAUSE_SEQ)
  ) u_gearbox_seq_counter (
    .i_txc        (i_txc),
    .i_reset_n    (i_reset_n),
    .o_txc2       (w_txc2),
    .o_gearbox_seq(w_seq),
    .o_tx_pause   (w_pause)
  );

  assign w_form_block = w_txc2 & ~w_pause;
  assign w_blk        = {r_word0, i_txd};
  assign w_blk_ctl    = {r_ctl0, i_txctl};
  assign w_blk_type   = classify_block(w_blk, w_blk_ctl);

  always_comb begin
    w_next_state = r_state;
    if (!i_init_done) begin
      w_next_state = INIT;
    end else begin
      unique case (r_state)
        INIT: w_next_state = C;
        C, T: begin
          unique case (w_blk_type)
            BT_C:    w_next_state = C;
            BT_S:    w_next_state = D;
            default: w_next_state = E;
          endcase
        end
        D: begin
          unique case (w_blk_type)
            BT_D:    w_next_state = D;
            BT_T:    w_next_state = T;
            default: w_next_state = E;
          endcase
        end
        E: begin
          unique case (w_blk_type)
            BT_C:       w_next_state = C;
            BT_S, BT_D: w_next_state = D;
            BT_T:       w_next_state = T;
            default:    w_next_state = E;
          endcase
        end
        default: w_next_state = INIT;
      endcase
    end
  end

  // Output is chosen by the state being entered, so the offending block itself becomes EBLOCK.
  always_comb begin
    w_out_txd = w_blk;
    w_out_ctl = w_blk_ctl;
    if (w_next_state == INIT) begin
      w_out_txd = LBLOCK;
      w_out_ctl = LBLOCK_CTL;
    end else if (w_next_state == E) begin
      w_out_txd = EBLOCK;
      w_out_ctl = EBLOCK_CTL;
    end
  end

  always_ff @(posedge i_txc or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_word0       <= '0;
      r_ctl0        <= '0;
      r_state       <= INIT;
      r_txd         <= LBLOCK;
      r_txctl       <= 8'hFF;
      r_block_valid <= 1'b0;
    end else begin
      r_block_valid <= w_form_block;
      if (!w_txc2 && !w_pause) begin
        r_word0 <= i_txd;
        r_ctl0  <= i_txctl;
      end
      if (w_form_block) begin
        r_state <= w_next_state;
        r_txd   <= w_out_txd;
        r_txctl <= w_out_ctl;
      end
    end
  end

  assign o_tx_pause    = w_pause;
  assign o_txd         = r_txd;
  assign o_txctl       = r_txctl;
  assign o_block_valid = r_block_valid;
  assign o_txc2        = w_txc2;
  assign o_gearbox_seq = w_seq;
  assign o_tx_state    = r_state;

endmodule

// File: tb/tb_tx_pcs_sequencer.sv
// Bench for tx_pcs_sequencer: directed block table, pause/reset sequences, random traffic vs model.
module tb_tx_pcs_sequencer;
  localparam int unsigned SEQ_MAX   = 32;
  localparam int unsigned PAUSE_SEQ = 32;
  localparam int S_INIT = 0, S_C = 1, S_D = 2, S_T = 3, S_E = 4;
  localparam logic [63:0] L_BLK = 64'h9C000001_9C000001;
  localparam logic [63:0] E_BLK = 64'hFEFEFEFE_FEFEFEFE;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        init_done = 1'b0;
  logic [0:31] txd = '0;
  logic [0:3]  txctl = '0;
  logic        tx_pause;
  logic [0:63] out_txd;
  logic [0:7]  out_ctl;
  logic        valid;
  logic        txc2;
  logic [5:0]  seq;
  logic [2:0]  st;

  tx_pcs_sequencer #(
    .SEQ_MAX  (SEQ_MAX),
    .PAUSE_SEQ(PAUSE_SEQ)
  ) dut (
    .i_txc        (clk),
    .i_reset_n    (rst_n),
    .i_init_done  (init_done),
    .i_txd        (txd),
    .i_txctl      (txctl),
    .o_tx_pause   (tx_pause),
    .o_txd        (out_txd),
    .o_txctl      (out_ctl),
    .o_block_valid(valid),
    .o_txc2       (txc2),
    .o_gearbox_seq(seq),
    .o_tx_state   (st)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int          m_cyc;
  int          m_state;
  logic        m_valid;
  logic [63:0] m_txd;
  logic [7:0]  m_ctl;
  logic [31:0] m_w0;
  logic [3:0]  m_c0;

  typedef struct {
    logic [31:0] w0;
    logic [3:0]  c0;
    logic [31:0] w1;
    logic [3:0]  c1;
    logic        init;
    logic [63:0] xd;
    logic [7:0]  xc;
    int          xs;
  } vec_t;
  vec_t tab[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One character per lane: d=data, I=idle, X=error, O=ordered set, S=start, T=terminate.
  function automatic string lane_codes(input logic [63:0] d, input logic [7:0] c);
    string s;
    logic [7:0] b;
    s = "";
    for (int i = 0; i < 8; i++) begin
      b = d[63-8*i -: 8];
      if (!c[7-i])          s = {s, "d"};
      else if (b == 8'h07)  s = {s, "I"};
      else if (b == 8'hFE)  s = {s, "X"};
      else if (b == 8'h9C)  s = {s, "O"};
      else if (b == 8'hFB)  s = {s, "S"};
      else if (b == 8'hFD)  s = {s, "T"};
      else                  s = {s, "?"};
    end
    return s;
  endfunction

  function automatic bit half_ok(input string h);
    bit ok;
    ok = 1'b1;
    for (int i = 0; i < 4; i++) if (h.getc(i) != "I" && h.getc(i) != "X") ok = 1'b0;
    return ok || (h == "Oddd");
  endfunction

  function automatic string m_classify(input string s);
    int k;
    bit tail;
    if (half_ok(s.substr(0, 3)) && half_ok(s.substr(4, 7))) return "C";
    if (s == "Sddddddd" || s == "IIIISddd") return "S";
    if (s == "dddddddd") return "D";
    k = 8;
    for (int i = 7; i >= 0; i--) if (s.getc(i) != "d") k = i;
    tail = (k < 8) && (s.getc(k) == "T");
    for (int i = 0; i < 8; i++) if (i > k && s.getc(i) != "I") tail = 1'b0;
    return tail ? "T" : "E";
  endfunction

  function automatic int m_next(input int s, input string k, input logic init);
    int n;
    if (!init) n = S_INIT;
    else if (s == S_INIT) n = S_C;
    else if (s == S_D) n = (k == "D") ? S_D : (k == "T") ? S_T : S_E;
    else if (s == S_E && (k == "D" || k == "T")) n = (k == "D") ? S_D : S_T;
    else n = (k == "C") ? S_C : (k == "S") ? S_D : S_E;
    return n;
  endfunction

  task automatic model_reset();
    m_cyc   = 0;
    m_state = S_INIT;
    m_valid = 1'b0;
    m_txd   = L_BLK;
    m_ctl   = 8'hFF;
    m_w0    = '0;
    m_c0    = '0;
  endtask

  task automatic check_all();
    int sq;
    sq = (m_cyc / 2) % (int'(SEQ_MAX) + 1);
    chk("txc2", 64'(txc2), 64'(m_cyc % 2));
    chk("gearbox_seq", 64'(seq), 64'(sq));
    chk("tx_pause", 64'(tx_pause), 64'(sq == int'(PAUSE_SEQ)));
    chk("block_valid", 64'(valid), 64'(m_valid));
    chk("txd", out_txd, m_txd);
    chk("txctl", 64'(out_ctl), 64'(m_ctl));
    chk("tx_state", 64'(st), 64'(m_state));
  endtask

  // Called at a falling edge: drive one word, clock it in, then check against the model.
  task automatic cycle(input logic [31:0] w, input logic [3:0] c, input logic init);
    bit ph, ps;
    logic [63:0] blk;
    logic [7:0]  bc;
    txd       = w;
    txctl     = c;
    init_done = init;
    ph = (m_cyc % 2) == 1;
    ps = ((m_cyc / 2) % (int'(SEQ_MAX) + 1)) == int'(PAUSE_SEQ);
    @(posedge clk);
    m_valid = 1'b0;
    if (!ps && !ph) begin
      m_w0 = w;
      m_c0 = c;
    end else if (!ps) begin
      blk = {m_w0, w};
      bc  = {m_c0, c};
      m_state = m_next(m_state, m_classify(lane_codes(blk, bc)), init);
      m_valid = 1'b1;
      if (m_state == S_INIT) begin
        m_txd = L_BLK;
        m_ctl = 8'h88;
      end else if (m_state == S_E) begin
        m_txd = E_BLK;
        m_ctl = 8'hFF;
      end else begin
        m_txd = blk;
        m_ctl = bc;
      end
    end
    m_cyc++;
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    txd       = '0;
    txctl     = '0;
    init_done = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
  endtask

  task automatic rand_word(output logic [31:0] w, output logic [3:0] c);
    int p;
    w = $urandom;
    c = 4'h0;
    case ($urandom_range(9, 0))
      0, 1, 2: begin w = 32'h07070707; c = 4'hF; end
      3, 4:    c = 4'h0;
      5:       begin w[31:24] = 8'hFB; c = 4'h8; end
      6: begin
        p = int'($urandom_range(3, 0));
        for (int j = 0; j < 4; j++) begin
          if (j >= p) begin
            c[3-j] = 1'b1;
            w[31-8*j -: 8] = (j == p) ? 8'hFD : 8'h07;
          end
        end
      end
      7:       begin w[31:24] = 8'h9C; c = 4'h8; end
      8:       begin w = ($urandom_range(1, 0) != 0) ? 32'hFEFEFEFE : 32'h07FE0707; c = 4'hF; end
      default: c = 4'($urandom);
    endcase
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int npause, nvalid;
    logic [31:0] rw;
    logic [3:0]  rc;
    logic        ri;

    tab[0]  = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0, L_BLK, 8'h88, S_INIT};
    tab[1]  = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b1, 64'h07070707_07070707, 8'hFF, S_C};
    tab[2]  = '{32'hFB555555, 4'h8, 32'h555555D5, 4'h0, 1'b1, 64'hFB555555_555555D5, 8'h80, S_D};
    tab[3]  = '{32'h01020304, 4'h0, 32'h05060708, 4'h0, 1'b1, 64'h01020304_05060708, 8'h00, S_D};
    tab[4]  = '{32'hFD070707, 4'hF, 32'h07070707, 4'hF, 1'b1, 64'hFD070707_07070707, 8'hFF, S_T};
    tab[5]  = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b1, 64'h07070707_07070707, 8'hFF, S_C};
    tab[6]  = '{32'h11223344, 4'h0, 32'h55667788, 4'h0, 1'b1, E_BLK, 8'hFF, S_E};
    tab[7]  = '{32'hFB555555, 4'h8, 32'h55555555, 4'h0, 1'b1, 64'hFB555555_55555555, 8'h80, S_D};
    tab[8]  = '{32'h01020304, 4'h0, 32'h0506FD07, 4'h3, 1'b1, 64'h01020304_0506FD07, 8'h03, S_T};
    tab[9]  = '{32'h9C000001, 4'h8, 32'h07070707, 4'hF, 1'b1, 64'h9C000001_07070707, 8'h8F, S_C};
    tab[10] = '{32'h07070707, 4'hF, 32'hFB112233, 4'h8, 1'b1, 64'h07070707_FB112233, 8'hF8, S_D};
    tab[11] = '{32'h12345678, 4'h4, 32'h00000000, 4'h0, 1'b1, E_BLK, 8'hFF, S_E};
    tab[12] = '{32'h07070707, 4'hF, 32'h07070707, 4'hF, 1'b0, L_BLK, 8'h88, S_INIT};

    // Reset values and idle blocks while initialisation is pending
    do_reset();
    chk("rst_txd", out_txd, L_BLK);
    chk("rst_txctl", 64'(out_ctl), 64'hFF);
    for (int b = 0; b < 10; b++) begin
      cycle(32'h07070707, 4'hF, 1'b0);
      cycle(32'h07070707, 4'hF, 1'b0);
      chk("init_lblock", out_txd, L_BLK);
      chk("init_ctl", 64'(out_ctl), 64'h88);
      chk("init_state", 64'(st), 64'(S_INIT));
    end

    for (int i = 0; i < 13; i++) begin
      cycle(tab[i].w0, tab[i].c0, tab[i].init);
      cycle(tab[i].w1, tab[i].c1, tab[i].init);
      chk("tab_valid", 64'(valid), 64'd1);
      chk("tab_txd", out_txd, tab[i].xd);
      chk("tab_txctl", 64'(out_ctl), 64'(tab[i].xc));
      chk("tab_state", 64'(st), 64'(tab[i].xs));
    end

    // Gearbox pause at sequence 32, with the MAC holding a start word across it
    do_reset();
    npause = 0;
    nvalid = 0;
    for (int k = 0; k < 70; k++) begin
      if (m_cyc >= 64 && m_cyc <= 66) cycle(32'hFB555555, 4'h8, 1'b1);
      else if (m_cyc == 67) cycle(32'h55555555, 4'h0, 1'b1);
      else cycle(32'h07070707, 4'hF, 1'b1);
      npause += int'(tx_pause);
      nvalid += int'(valid);
      if (m_cyc == 64 || m_cyc == 65) chk("pause_seq32", 64'(tx_pause), 64'd1);
      if (m_cyc == 66) begin
        chk("pause_no_block", 64'(valid), 64'd0);
        chk("seq_wrap", 64'(seq), 64'd0);
      end
      if (m_cyc == 68) begin
        chk("pause_held_word", out_txd, 64'hFB555555_55555555);
        chk("pause_held_state", 64'(st), 64'(S_D));
      end
    end
    chk("pause_count", 64'(npause), 64'd2);
    chk("valid_count", 64'(nvalid), 64'd34);

    // Asynchronous reset while the second word of a block is on the bus
    do_reset();
    cycle(32'h07070707, 4'hF, 1'b1);
    cycle(32'h07070707, 4'hF, 1'b1);
    cycle(32'h11111111, 4'h0, 1'b1);
    chk("mid_phase1", 64'(txc2), 64'd1);
    txd   = 32'h22222222;
    txctl = 4'h0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_txc2", 64'(txc2), 64'd0);
    chk("mid_rst_seq", 64'(seq), 64'd0);
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_txd", out_txd, L_BLK);
    chk("mid_rst_txctl", 64'(out_ctl), 64'hFF);
    chk("mid_rst_state", 64'(st), 64'(S_INIT));
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check_all();
    cycle(32'hFB555555, 4'h8, 1'b1);
    cycle(32'h55555555, 4'h0, 1'b1);
    chk("mid_restart_txd", out_txd, 64'hFB555555_55555555);
    chk("mid_restart_ctl", 64'(out_ctl), 64'h80);
    chk("mid_restart_state", 64'(st), 64'(S_C));

    // Random traffic against the reference model
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      rand_word(rw, rc);
      ri = ($urandom_range(49, 0) != 0);
      cycle(rw, rc, ri);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_pcs_sequencer.md
Name: tx_pcs_sequencer

Overview:
Transmit-side controller between the 32-bit MAC interface and the encode_6466b datapath. It pairs MAC words into 64-bit blocks on a half-rate phase and sequences the 33-period gearbox pause back to the MAC. It also runs the Clause 49 transmit state machine (INIT/C/D/T/E), forcing error or fault blocks into the encoder on illegal control sequences.

Parameters:
SEQ_MAX, 32, last gearbox sequence value; pause period is SEQ_MAX+1 block periods
PAUSE_SEQ, 32, sequence value at which the block period is paused

Ports:
i_txc  in  1  transmit clock, one 32-bit word per cycle
i_reset_n  in  1  asynchronous active-low reset
i_init_done  in  1  PCS/transceiver initialisation complete, level
i_txd  in  [0:31]  MAC data, lane 0 = bits 0:7
i_txctl  in  [0:3]  MAC per-lane control flags
o_tx_pause  out  1  MAC must hold i_txd/i_txctl this cycle
o_txd  out  [0:63]  sequenced block data to encoder
o_txctl  out  [0:7]  sequenced block control to encoder
o_block_valid  out  1  o_txd/o_txctl carry a new block (one cycle per block)
o_txc2  out  1  word phase: 0 = first word, 1 = second word of block
o_gearbox_seq  out  [5:0]  current gearbox sequence, to gearbox
o_tx_state  out  [2:0]  current tx_state_t, for debug/status

Behaviour:
- Async reset (i_reset_n=0) → o_txc2=0, o_gearbox_seq=0, o_tx_pause=0, o_block_valid=0, o_txctl=8'hff, o_txd=LBLOCK, state=INIT. LBLOCK = 9C000001_9C000001, ctl 8'h88.
- Phase: o_txc2 toggles every cycle. o_gearbox_seq increments when o_txc2=1, wrapping SEQ_MAX→0.
- Pause: o_tx_pause=1 for both cycles of the pair where o_gearbox_seq==PAUSE_SEQ. Result: 32 data blocks per 33 block periods.
- Pause cycles: input is ignored; no block is formed; o_block_valid=0.
- Assembly: phase-0 word/ctl is registered. On the phase-1 cycle, {held, current} is classified.
- Output timing: o_txd/o_txctl/o_block_valid update on the clock edge after the phase-1 cycle (latency 1 from second word). o_block_valid is a 1-cycle pulse; data holds until the next block.
- Classification (on the 64-bit block):
  - C: all ctl lanes with 07/FE/ordered set 9C.
  - S: lane 0 or lane 4 = FB ctl, lanes after it data, lanes before (lane-4 case) 07.
  - D: ctl==0.
  - T: first ctl lane = FD, all following lanes 07 ctl, earlier lanes data.
  - E: anything else.
- State machine (advances once per formed block):
  - INIT: output LBLOCK. When i_init_done=1 at a block boundary → C.
  - C: C→C, S→D, else →E.
  - D: D→D, T→T, else →E.
  - T: C→C, S→D, else →E.
  - E: D→D, T→T, C→C, S→D, else stay E.
- State output: in C/D/T the classified block is passed unmodified. When entering or remaining in E, the block is replaced by EBLOCK = FE×8, ctl 8'hff.
- i_init_done deasserted in any state → INIT at the next block boundary.
- Mid-block reset: the partial word is discarded; restart at phase 0, seq 0.
- Phase 0 coinciding with pause: pause wins and phase still toggles.

Decomposition:
- Package pcs_pkg:
  - typedef enum tx_state_t {INIT, C, D, T, E}
  - typedef enum blk_type_t {BT_C, BT_S, BT_D, BT_T, BT_E}
  - constants CTL_IDLE=07, CTL_START=FB, CTL_TERM=FD, CTL_ERROR=FE, CTL_SEQ=9C, LBLOCK, EBLOCK
  - function classify_block.
- Sub-module gearbox_seq_counter: phase toggle, 0..SEQ_MAX sequence, o_tx_pause generation.

Test Plan:
- Reset release, i_init_done=0, 10 blocks of idle → o_txd=LBLOCK, ctl 8'h88 each block; state stays INIT.
- i_init_done=1, words 07070707/f, 07070707/f → next block C, o_txd=0707070707070707, ctl ff, valid 1 cycle after second word.
- Run 70 cycles → o_tx_pause high exactly at cycles 64,65 (seq 32). No o_block_valid pulse in that pair. MAC word held across pause appears in the next block.
- Sequence C, S (FB555555/8, 55555555D5.../0), D, T (FD070707/f, 07070707/f), C → state path C→D→D→T→C. Blocks pass unmodified.
- D block directly after C (ctl 00) → state E, output EBLOCK FE×8/ff. Next legal S → D, passes through.
- Assert i_reset_n low during phase 1 of a block → outputs return to reset values immediately (async). After release, first word is treated as phase 0 and seq restarts at 0.
